data_mem_unit: RTL and testbench

Data-memory responder for the single-issue RV32IM core. It consumes the `mem_read`/`mem_write` strobes produced by the opcode decoder, together with `funct3`, the ALU-computed address and rs2 store data. It performs byte, halfword and word loads and stores against an internal word-organised array, with a fixed, parameterised access latency. It reports completion through a one-cycle `done` pulse and holds the pipeline through `busy`.

---
 rtl/data_mem_unit_if.sv | 14 +
 rtl/data_mem_unit.sv | 98 +++++++++
 tb/tb_data_mem_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_unit_if.sv
// data_mem_unit_if: decoder-to-data-memory request/response bundle
interface data_mem_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  modport master (output mem_read, mem_write, funct3, addr, wdata, input rdata, busy, done, err);
  modport slave (input mem_read, mem_write, funct3, addr, wdata, output rdata, busy, done, err);
endinterface

// File: rtl/data_mem_unit.sv
// data_mem_unit: fixed-latency byte/half/word data memory with done/err completion
module data_mem_unit #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  data_mem_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0] f3_q, f3_d;
  logic wr_q, wr_d, err_q, err_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic req, bad, commit, we;
  logic [3:0] be;
  logic [31:0] wd, word, ld;
  logic [7:0] byte_s;
  logic [15:0] half;
  always_comb begin
    req = bus.mem_read | bus.mem_write;
    bad = (bus.mem_read & bus.mem_write)
        | (bus.funct3[1:0] == 2'b11)
        | (bus.funct3[2] & (bus.mem_write | bus.funct3[1]))
        | ((bus.funct3[1:0] == 2'b01) & bus.addr[0])
        | ((bus.funct3[1:0] == 2'b10) & |bus.addr[1:0])
        | (bus.addr[31:2] >= 30'(DEPTH_WORDS));
    word = mem[addr_q[AW+1:2]];
    byte_s = word[{addr_q[1:0], 3'b000} +: 8];
    half = addr_q[1] ? word[31:16] : word[15:0];
    ld = f3_q[1] ? word
       : f3_q[0] ? {{16{half[15] & ~f3_q[2]}}, half}
       : {{24{byte_s[7] & ~f3_q[2]}}, byte_s};
    be = f3_q[1] ? 4'hf : f3_q[0] ? (addr_q[1] ? 4'hc : 4'h3) : 4'b0001 << addr_q[1:0];
    wd = f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    commit = (state_q == WAIT) & (cnt_q == 4'd0) & ~err_q;
    we = rst_n & commit & wr_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    f3_d = f3_q;
    wr_d = wr_q;
    err_d = err_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && req) begin
      state_d = WAIT;
      cnt_d = bad ? 4'd0 : 4'(LATENCY - 1);
      addr_d = bus.addr[AW+1:0];
      wdata_d = bus.wdata;
      f3_d = bus.funct3;
      wr_d = bus.mem_write;
      err_d = bad;
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd0) ? DONE : WAIT;
      cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      rdata_d = (commit & ~wr_q) ? ld : rdata_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      f3_q <= f3_d;
      wr_q <= wr_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  end
  assign bus.rdata = rdata_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.err = (state_q == DONE) & err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed checks of data_mem_unit loads, stores, errors, reset and latency
module tb_data_mem_unit;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sreq = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  data_mem_unit_if m();
  data_mem_unit_if s1();
  data_mem_unit_if s4();
  data_mem_unit_if s15();
  data_mem_unit #(.DEPTH_WORDS(DW), .LATENCY(2)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  data_mem_unit #(.DEPTH_WORDS(DW), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(s1));
  data_mem_unit #(.DEPTH_WORDS(DW), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(s4));
  data_mem_unit #(.DEPTH_WORDS(DW), .LATENCY(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(s15));
  assign s1.mem_read = 1'b0;
  assign s1.mem_write = sreq;
  assign s1.funct3 = 3'b010;
  assign s1.addr = 32'h4;
  assign s1.wdata = 32'h5a5a5a5a;
  assign s4.mem_read = 1'b0;
  assign s4.mem_write = sreq;
  assign s4.funct3 = 3'b010;
  assign s4.addr = 32'h4;
  assign s4.wdata = 32'h5a5a5a5a;
  assign s15.mem_read = 1'b0;
  assign s15.mem_write = sreq;
  assign s15.funct3 = 3'b010;
  assign s15.addr = 32'h4;
  assign s15.wdata = 32'h5a5a5a5a;

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic e, output logic [31:0] ro,
                        output logic bdrop);
    @(posedge clk); #1;
    m.mem_read = rd; m.mem_write = wr; m.funct3 = f3; m.addr = a; m.wdata = wd;
    @(posedge clk); #1;
    m.mem_read = 1'b0; m.mem_write = 1'b0; m.addr = 32'hffff_fffc; m.wdata = 32'h0;
    lat = -1; e = 1'bx; ro = 32'hx; bdrop = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!m.busy) bdrop = 1'b1;
      if (m.done) begin
        lat = n - 1; e = m.err; ro = m.rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (m.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", m.busy); end
    checks++; if (m.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", m.done); end
    checks++; if (m.err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", m.err); end
    checks++; if (m.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", m.rdata); end
  endtask

  task automatic test_word();
    int lat; logic e, bd; logic [31:0] r;
    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hdeadbeef, lat, e, r, bd);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sw_err got %b want 0", e); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL sw_busy_drop got %b want 0", bd); end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, lat, e, r, bd);
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got %0d want 2", lat); end
    checks++; if (r !== 32'hdeadbeef) begin failures++; $display("FAIL lw_data got %h want deadbeef", r); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL lw_err got %b want 0", e); end
  endtask

  task automatic test_bytes();
    int lat; logic e, bd; logic [31:0] r;
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'h12345680, lat, e, r, bd);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sb_err got %b want 0", e); end
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'hffffff80) begin failures++; $display("FAIL lb_data got %h want ffffff80", r); end
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h00000080) begin failures++; $display("FAIL lbu_data got %h want 00000080", r); end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h80adbeef) begin failures++; $display("FAIL lw_after_sb got %h want 80adbeef", r); end
  endtask

  task automatic test_halves();
    int lat; logic e, bd; logic [31:0] r;
    access(1'b0, 1'b1, 3'b001, 32'h12, 32'habcd8001, lat, e, r, bd);
    access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'hffff8001) begin failures++; $display("FAIL lh_data got %h want ffff8001", r); end
    access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h00008001) begin failures++; $display("FAIL lhu_data got %h want 00008001", r); end
    access(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, lat, e, r, bd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL lh_misaligned_latency got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL lh_misaligned_err got %b want 1", e); end
    checks++; if (r !== 32'h00008001) begin failures++; $display("FAIL lh_misaligned_rdata got %h want 00008001", r); end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h8001beef) begin failures++; $display("FAIL lw_after_sh got %h want 8001beef", r); end
  endtask

  task automatic test_illegal();
    int lat; logic e, bd; logic [31:0] r;
    access(1'b0, 1'b1, 3'b010, 32'h0, 32'h01234567, lat, e, r, bd);
    access(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, lat, e, r, bd);
    checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL lw_misaligned got lat=%0d err=%b want lat=1 err=1", lat, e); end
    checks++; if (r !== 32'h8001beef) begin failures++; $display("FAIL lw_misaligned_rdata got %h want 8001beef", r); end
    access(1'b0, 1'b1, 3'b010, DW * 4, 32'hffffffff, lat, e, r, bd);
    checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL sw_range got lat=%0d err=%b want lat=1 err=1", lat, e); end
    access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h01234567) begin failures++; $display("FAIL sw_range_readback got %h want 01234567", r); end
    access(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, lat, e, r, bd);
    checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL both_high got lat=%0d err=%b want lat=1 err=1", lat, e); end
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h8001beef) begin failures++; $display("FAIL both_high_readback got %h want 8001beef", r); end
    access(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, lat, e, r, bd);
    access(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, lat, e, r, bd);
    checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL load_f3_011 got lat=%0d err=%b want lat=1 err=1", lat, e); end
    checks++; if (r !== 32'h00000067) begin failures++; $display("FAIL load_f3_011_rdata got %h want 00000067", r); end
    access(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, lat, e, r, bd);
    checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL store_f3_100 got lat=%0d err=%b want lat=1 err=1", lat, e); end
    access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h01234567) begin failures++; $display("FAIL store_f3_100_readback got %h want 01234567", r); end
  endtask

  task automatic test_back_to_back();
    int lat; logic e, bd; logic [31:0] r;
    access(1'b0, 1'b1, 3'b010, 32'h20, 32'hcafef00d, lat, e, r, bd);
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'hcafef00d) begin failures++; $display("FAIL b2b_readback got %h want cafef00d", r); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL b2b_latency got %0d want 2", lat); end
  endtask

  task automatic test_reset_wait();
    int lat, seen; logic e, bd; logic [31:0] r;
    access(1'b0, 1'b1, 3'b010, 32'h14, 32'h11112222, lat, e, r, bd);
    @(posedge clk); #1;
    m.mem_read = 1'b0; m.mem_write = 1'b1; m.funct3 = 3'b010; m.addr = 32'h14; m.wdata = 32'h99999999;
    @(posedge clk); #1;
    m.mem_write = 1'b0;
    rst_n = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (m.done) seen++;
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_wait_done got %0d pulses want 0", seen); end
    checks++; if (m.busy !== 1'b0) begin failures++; $display("FAIL reset_wait_busy got %b want 0", m.busy); end
    access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, lat, e, r, bd);
    checks++; if (r !== 32'h11112222) begin failures++; $display("FAIL reset_wait_readback got %h want 11112222", r); end
  endtask

  task automatic test_latency_sweep();
    int lv[3] = '{1, 4, 15};
    int last[3] = '{-1, -1, -1};
    int low[3] = '{0, 0, 0};
    int nd[3] = '{0, 0, 0};
    logic pd[3] = '{1'b0, 1'b0, 1'b0};
    logic [2:0] dn, bz;
    @(posedge clk); #1 sreq = 1'b1;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      dn = {s15.done, s4.done, s1.done};
      bz = {s15.busy, s4.busy, s1.busy};
      for (int j = 0; j < 3; j++) begin
        if (dn[j]) begin
          checks++; if (pd[j]) begin failures++; $display("FAIL sweep_width lat=%0d got 2+ cycles want 1", lv[j]); end
          if (last[j] >= 0) begin
            checks++; if (c - last[j] !== lv[j] + 2) begin failures++; $display("FAIL sweep_period lat=%0d got %0d want %0d", lv[j], c - last[j], lv[j] + 2); end
            checks++; if (low[j] !== 1) begin failures++; $display("FAIL sweep_busy lat=%0d got %0d idle cycles want 1", lv[j], low[j]); end
          end
          last[j] = c; low[j] = 0; nd[j]++;
        end
        if (!bz[j]) low[j]++;
        pd[j] = dn[j];
      end
    end
    #1 sreq = 1'b0;
    repeat (20) @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++; if (nd[j] < 3) begin failures++; $display("FAIL sweep_count lat=%0d got %0d want >=3", lv[j], nd[j]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    m.mem_read = 1'b0; m.mem_write = 1'b0; m.funct3 = 3'b000; m.addr = 32'h0; m.wdata = 32'h0;
    test_reset();
    test_word();
    test_bytes();
    test_halves();
    test_illegal();
    test_back_to_back();
    test_reset_wait();
    test_latency_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
